// File: rtl/mem_port_arbiter.sv
// Arbitrates one memory port between instruction fetch and data load/store, one access in flight.
// Grant edge N -> mem_en from N+1; ready pulse the cycle after mem_ack; requesters stall until their ready.
module mem_port_arbiter #(
  parameter int TIMEOUT     = 16,
  parameter int MAX_DSTREAK = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        bus_err,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall_if,
  output logic        stall_mem
);

  localparam int SW = $clog2(MAX_DSTREAK + 2);
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, IF_ACC, D_ACC} state_t;

  state_t        r_state;
  logic [SW-1:0] r_streak;
  logic [WW-1:0] r_wait;
  logic          r_mem_en;
  logic          r_mem_we;
  logic [31:0]   r_mem_addr;
  logic [31:0]   r_mem_wdata;
  logic [31:0]   r_if_rdata;
  logic [31:0]   r_d_rdata;
  logic          r_if_ready;
  logic          r_d_ready;
  logic          r_bus_err;

  logic w_d_req;
  logic w_d_elig;
  logic w_if_elig;
  logic w_if_turn;

  assign w_d_req   = MemRead | MemWrite;
  assign w_d_elig  = w_d_req & ~r_d_ready;
  assign w_if_elig = if_req & ~r_if_ready;
  assign w_if_turn = (r_streak == SW'(MAX_DSTREAK)) & w_if_elig;

  assign stall_if  = w_if_elig;
  assign stall_mem = w_d_elig;

  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;
  assign if_ready  = r_if_ready;
  assign d_ready   = r_d_ready;
  assign bus_err   = r_bus_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_streak    <= '0;
      r_wait      <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
      r_if_ready  <= 1'b0;
      r_d_ready   <= 1'b0;
      r_bus_err   <= 1'b0;
    end else begin
      r_if_ready <= 1'b0;
      r_d_ready  <= 1'b0;
      r_bus_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          // A data request still high in its own ready cycle is taken as a
          // back-to-back access: it keeps fetch off the bus unless fetch is owed a turn.
          if (w_d_req && !w_if_turn) begin
            if (w_d_elig) begin
              r_state     <= D_ACC;
              r_wait      <= '0;
              r_mem_en    <= 1'b1;
              r_mem_we    <= MemWrite;
              r_mem_addr  <= d_addr;
              r_mem_wdata <= MemWrite ? d_wdata : 32'h0;
              if (w_if_elig) begin
                r_streak <= (r_streak == SW'(MAX_DSTREAK)) ? r_streak : r_streak + SW'(1);
              end else begin
                r_streak <= '0;
              end
            end else if (!w_if_elig) begin
              r_streak <= '0;
            end
          end else if (w_if_elig) begin
            r_state     <= IF_ACC;
            r_wait      <= '0;
            r_mem_en    <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= if_addr;
            r_mem_wdata <= 32'h0;
            r_streak    <= '0;
          end else begin
            r_streak <= '0;
          end
        end
        IF_ACC, D_ACC: begin
          if (mem_ack) begin
            r_state  <= IDLE;
            r_mem_en <= 1'b0;
            if (r_state == IF_ACC) begin
              r_if_ready <= 1'b1;
              r_if_rdata <= mem_rdata;
            end else begin
              r_d_ready <= 1'b1;
              r_d_rdata <= r_mem_we ? 32'h0 : mem_rdata;
            end
          end else if (r_wait == WW'(TIMEOUT - 1)) begin
            r_state   <= IDLE;
            r_mem_en  <= 1'b0;
            r_bus_err <= 1'b1;
            if (r_state == IF_ACC) begin
              r_if_ready <= 1'b1;
              r_if_rdata <= 32'h0;
            end else begin
              r_d_ready <= 1'b1;
              r_d_rdata <= 32'h0;
            end
          end else begin
            r_wait <= r_wait + WW'(1);
          end
        end
        default: begin
          r_state  <= IDLE;
          r_mem_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: the bench plays both CPU and memory.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        bus_err;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        stall_if;
  logic        stall_mem;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.TIMEOUT(16), .MAX_DSTREAK(2)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .MemRead(mem_read), .MemWrite(mem_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready), .bus_err(bus_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  typedef struct {
    logic        ifr, rd, wr;
    logic [31:0] ia, da, dw, mrd;
    logic        xwe;
    logic [31:0] xaddr, xwdata;
    logic        xfetch;
    logic [31:0] xrdata;
    logic        xsif, xsmem;
  } vec_t;

  vec_t vt[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic drop_all();
    if_req = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cnt;
    logic ord[4];
    logic seen;

    //        ifr   rd    wr    ia        da        dw            mrd           xwe   xaddr     xwdata        xfetch xrdata      xsif  xsmem
    vt[0] = '{1'b1, 1'b0, 1'b0, 32'h100,  32'h0,    32'h0,        32'h00000013, 1'b0, 32'h100,  32'h0,        1'b1,  32'h00000013, 1'b1, 1'b0};
    vt[1] = '{1'b0, 1'b1, 1'b0, 32'h0,    32'h2000, 32'h0,        32'h12345678, 1'b0, 32'h2000, 32'h0,        1'b0,  32'h12345678, 1'b0, 1'b1};
    vt[2] = '{1'b0, 1'b1, 1'b1, 32'h0,    32'h40,   32'hDEADBEEF, 32'h55AA55AA, 1'b1, 32'h40,   32'hDEADBEEF, 1'b0,  32'h0,        1'b0, 1'b1};
    vt[3] = '{1'b0, 1'b0, 1'b1, 32'h0,    32'h3004, 32'hCAFEF00D, 32'h99999999, 1'b1, 32'h3004, 32'hCAFEF00D, 1'b0,  32'h0,        1'b0, 1'b1};
    vt[4] = '{1'b1, 1'b1, 1'b0, 32'h200,  32'h300,  32'h0,        32'h0BADF00D, 1'b0, 32'h300,  32'h0,        1'b0,  32'h0BADF00D, 1'b1, 1'b1};

    reset = 1'b1;
    drop_all();
    if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst mem_en", mem_en, 0);
    chk("rst mem_we", mem_we, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst mem_wdata", mem_wdata, 0);
    chk("rst if_rdata", if_rdata, 0);
    chk("rst d_rdata", d_rdata, 0);
    chk("rst ready", {if_ready, d_ready, bus_err}, 0);
    reset = 1'b0;
    @(negedge clk);

    // Single accesses from IDLE, acked in the first mem_en cycle.
    for (int i = 0; i < 5; i++) begin
      if_req = vt[i].ifr; mem_read = vt[i].rd; mem_write = vt[i].wr;
      if_addr = vt[i].ia; d_addr = vt[i].da; d_wdata = vt[i].dw;
      #1;
      chk($sformatf("v%0d stall_if", i), stall_if, vt[i].xsif);
      chk($sformatf("v%0d stall_mem", i), stall_mem, vt[i].xsmem);
      @(negedge clk);
      chk($sformatf("v%0d mem_en", i), mem_en, 1);
      chk($sformatf("v%0d mem_we", i), mem_we, vt[i].xwe);
      chk($sformatf("v%0d mem_addr", i), mem_addr, vt[i].xaddr);
      chk($sformatf("v%0d mem_wdata", i), mem_wdata, vt[i].xwdata);
      mem_ack = 1'b1; mem_rdata = vt[i].mrd;
      @(negedge clk);
      mem_ack = 1'b0;
      chk($sformatf("v%0d mem_en after ack", i), mem_en, 0);
      chk($sformatf("v%0d if_ready", i), if_ready, vt[i].xfetch);
      chk($sformatf("v%0d d_ready", i), d_ready, {31'b0, ~vt[i].xfetch});
      chk($sformatf("v%0d bus_err", i), bus_err, 0);
      chk($sformatf("v%0d rdata", i), vt[i].xfetch ? if_rdata : d_rdata, vt[i].xrdata);
      drop_all();
      @(negedge clk);
      chk($sformatf("v%0d ready pulse width", i), {if_ready, d_ready, mem_en}, 0);
      chk($sformatf("v%0d rdata held", i), vt[i].xfetch ? if_rdata : d_rdata, vt[i].xrdata);
    end

    // mem_ack while idle must do nothing.
    mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    mem_ack = 1'b0;
    @(negedge clk);
    chk("idle ack readies", {if_ready, d_ready, mem_en}, 0);
    chk("idle ack d_rdata", d_rdata, 32'h0BADF00D);

    // Fetch acked in the third mem_en cycle.
    if_req = 1'b1; if_addr = 32'h100;
    @(negedge clk);
    chk("f3 mem_addr c1", mem_addr, 32'h100);
    @(negedge clk);
    chk("f3 mem_en c2", {mem_en, mem_we}, 2'b10);
    @(negedge clk);
    chk("f3 stable c3", {mem_en, mem_addr}, {1'b1, 32'h100});
    mem_ack = 1'b1; mem_rdata = 32'h00500093;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("f3 if_ready", {if_ready, stall_if, mem_en}, 3'b100);
    chk("f3 if_rdata", if_rdata, 32'h00500093);
    if_req = 1'b0;
    @(negedge clk);

    // Simultaneous fetch and load: data first, fetch right after d_ready.
    if_req = 1'b1; if_addr = 32'h400; mem_read = 1'b1; d_addr = 32'h500;
    @(negedge clk);
    chk("pri data grant", {mem_en, mem_we, mem_addr}, {2'b10, 32'h500});
    mem_ack = 1'b1; mem_rdata = 32'h11112222;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("pri d_ready", {d_ready, d_rdata}, {1'b1, 32'h11112222});
    mem_read = 1'b0;
    @(negedge clk);
    chk("pri fetch grant", {mem_en, mem_we, mem_addr}, {2'b10, 32'h400});
    mem_ack = 1'b1; mem_rdata = 32'h33334444;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("pri if_ready", {if_ready, if_rdata}, {1'b1, 32'h33334444});
    if_req = 1'b0;
    @(negedge clk);

    // Back-to-back stores with fetch held: grant order D, D, IF, D.
    if_req = 1'b1; if_addr = 32'h600; mem_write = 1'b1; d_addr = 32'h700; d_wdata = 32'h1;
    n = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      @(negedge clk);
      if (mem_en) begin
        ord[n] = mem_we;
        n++;
        mem_ack = 1'b1; mem_rdata = 32'h0;
      end else begin
        mem_ack = 1'b0;
      end
    end
    @(negedge clk);
    mem_ack = 1'b0;
    drop_all();
    chk("streak grants seen", n, 4);
    chk("streak order (1=D,0=IF)", {ord[0], ord[1], ord[2], ord[3]}, 4'b1101);
    repeat (2) @(negedge clk);

    // Load never acked: abort after 16 mem_en cycles.
    mem_read = 1'b1; d_addr = 32'h900;
    cnt = 0; seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (d_ready) begin
        seen = 1'b1;
        chk("tmo mem_en", mem_en, 0);
        chk("tmo bus_err", bus_err, 1);
        chk("tmo d_rdata", d_rdata, 0);
      end else if (mem_en) begin
        cnt++;
      end
    end
    chk("tmo ready seen", seen, 1);
    chk("tmo mem_en cycles", cnt, 16);
    mem_read = 1'b0;
    @(negedge clk);
    chk("tmo bus_err pulse", {bus_err, d_ready}, 0);

    // Fetch request dropped mid-access still completes.
    if_req = 1'b1; if_addr = 32'h800;
    @(negedge clk);
    chk("drop mem_en", mem_en, 1);
    if_req = 1'b0;
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'h77;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("drop if_ready", {if_ready, if_rdata}, {1'b1, 32'h77});
    @(negedge clk);

    // Asynchronous reset in the middle of a data access.
    mem_read = 1'b1; d_addr = 32'hA00;
    @(negedge clk);
    chk("arst pre mem_en", mem_en, 1);
    #2 reset = 1'b1;
    #1;
    chk("arst mem_en/d_ready", {mem_en, d_ready}, 0);
    chk("arst mem_addr", mem_addr, 0);
    chk("arst if_rdata", if_rdata, 0);
    mem_read = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (mem_en) cnt++;
    end
    chk("post-reset idle mem_en", cnt, 0);
    if_req = 1'b1; if_addr = 32'hB00;
    @(negedge clk);
    chk("post-reset grant", {mem_en, mem_addr}, {1'b1, 32'hB00});
    mem_ack = 1'b1; mem_rdata = 32'h5;
    @(negedge clk);
    mem_ack = 1'b0;
    if_req = 1'b0;
    chk("post-reset if_ready", {if_ready, if_rdata}, {1'b1, 32'h5});
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
